// File: rtl/hvac_actuator_ctrl.sv
// Heat/cool actuator sequencer with minimum on/off timing and conflict flag.
// Define FAN_OVERRUN_EN to keep the blower running into the rest phase.
module hvac_actuator_ctrl #(
    parameter int MIN_ON_CYC   = 8,
    parameter int MIN_OFF_CYC  = 8,
    parameter int FAN_POST_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic heat,
    input  logic cool,
    output logic heater_en,
    output logic comp_en,
    output logic fan_en,
    output logic busy,
    output logic conflict
);

    if (MIN_ON_CYC < 1 || MIN_ON_CYC > 255 ||
        MIN_OFF_CYC < 1 || MIN_OFF_CYC > 255 ||
        FAN_POST_CYC < 1 || FAN_POST_CYC > 255) begin : g_bad_param
        $error("hvac_actuator_ctrl: parameter out of range 1..255");
    end

    typedef enum logic [1:0] {
        IDLE,
        HEAT,
        COOL,
        REST
    } state_t;

    localparam logic [7:0] ON_LAST  = 8'(MIN_ON_CYC - 1);
    localparam logic [7:0] OFF_LAST = 8'(MIN_OFF_CYC - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] on_cnt;
    logic [7:0] on_nx;
    logic [7:0] off_cnt;
    logic [7:0] off_nx;
    logic       heat_req;
    logic       cool_req;
    logic       fan_d;

    // Both requests at once count as no request at all.
    assign heat_req = heat & ~cool;
    assign cool_req = cool & ~heat;

    always_comb begin
        state_nx = state;
        on_nx    = on_cnt;
        off_nx   = off_cnt;
        unique case (state)
            IDLE: begin
                on_nx  = '0;
                off_nx = '0;
                if (heat_req) begin
                    state_nx = HEAT;
                end else if (cool_req) begin
                    state_nx = COOL;
                end
            end
            HEAT: begin
                if (on_cnt != ON_LAST) begin
                    on_nx = on_cnt + 8'd1;
                end
                if (!heat_req && on_cnt == ON_LAST) begin
                    state_nx = REST;
                    on_nx    = '0;
                    off_nx   = '0;
                end
            end
            COOL: begin
                if (on_cnt != ON_LAST) begin
                    on_nx = on_cnt + 8'd1;
                end
                if (!cool_req && on_cnt == ON_LAST) begin
                    state_nx = REST;
                    on_nx    = '0;
                    off_nx   = '0;
                end
            end
            REST: begin
                on_nx  = '0;
                off_nx = off_cnt + 8'd1;
                if (off_cnt == OFF_LAST) begin
                    state_nx = IDLE;
                    off_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

`ifdef FAN_OVERRUN_EN
    localparam logic [7:0] FAN_LAST = 8'(FAN_POST_CYC);

    logic [7:0] fan_cnt;
    logic [7:0] fan_nx;

    // Rest phase is only MIN_OFF_CYC long, so the overrun is clipped there.
    always_comb begin
        fan_nx = '0;
        if (state_nx == REST && state == REST) begin
            fan_nx = (fan_cnt == FAN_LAST) ? fan_cnt
                                           : fan_cnt + 8'd1;
        end
        fan_d = (state_nx == HEAT) || (state_nx == COOL) ||
                (state_nx == REST && fan_nx < FAN_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fan_cnt <= '0;
        end else begin
            fan_cnt <= fan_nx;
        end
    end
`else
    always_comb begin
        fan_d = (state_nx == HEAT) || (state_nx == COOL);
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            on_cnt    <= '0;
            off_cnt   <= '0;
            heater_en <= 1'b0;
            comp_en   <= 1'b0;
            fan_en    <= 1'b0;
            busy      <= 1'b0;
            conflict  <= 1'b0;
        end else begin
            state     <= state_nx;
            on_cnt    <= on_nx;
            off_cnt   <= off_nx;
            heater_en <= (state_nx == HEAT);
            comp_en   <= (state_nx == COOL);
            fan_en    <= fan_d;
            busy      <= (state_nx != IDLE);
            conflict  <= conflict | (heat & cool);
        end
    end

endmodule

// File: doc/hvac_actuator_ctrl.md
HVAC_ACTUATOR_CTRL -- requirements
Module: hvac_actuator_ctrl

Interface
REQ-001 SHALL have parameter MIN_ON_CYC, default 8: minimum cycles heater_en/comp_en stays high once asserted (legal range 1..255).
REQ-002 SHALL have parameter MIN_OFF_CYC, default 8: minimum rest cycles after heating or cooling stops before any restart (legal range 1..255).
REQ-003 SHALL have parameter FAN_POST_CYC, default 4: fan overrun cycles after an active phase ends (legal range 1..255; used only with FAN_OVERRUN_EN).
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port heat, input, 1 bit: heating request from the upstream thermostat comparator.
REQ-007 SHALL have port cool, input, 1 bit: cooling request from the upstream thermostat comparator.
REQ-008 SHALL have port heater_en, output, 1 bit: heater drive.
REQ-009 SHALL have port comp_en, output, 1 bit: compressor drive.
REQ-010 SHALL have port fan_en, output, 1 bit: blower drive.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL have port conflict, output, 1 bit: sticky flag, set when heat and cool are sampled high together.

Function
REQ-013 SHALL implement exactly four states: IDLE, HEAT, COOL, REST; all outputs registered.
REQ-014 IDLE: SHALL go to HEAT if heat=1 and cool=0, go to COOL if cool=1 and heat=0, and otherwise stay in IDLE.
REQ-015 HEAT: on_cnt SHALL clear on entry and increment each cycle, saturating at MIN_ON_CYC-1.
REQ-016 HEAT: SHALL go to REST when (heat=0 or cool=1) and on_cnt=MIN_ON_CYC-1, and otherwise stay in HEAT.
REQ-017 COOL: SHALL behave as HEAT with heat and cool swapped.
REQ-018 SHALL never transition HEAT->COOL or COOL->HEAT directly; the only path between them is through REST and then IDLE.
REQ-019 REST: off_cnt SHALL clear on entry and increment each cycle; the block SHALL go to IDLE when off_cnt=MIN_OFF_CYC-1, ignoring heat and cool while in REST.
REQ-020 heater_en SHALL be 1 exactly while state=HEAT, and comp_en SHALL be 1 exactly while state=COOL; heater_en and comp_en SHALL never both be 1.
REQ-021 Latency: a request sampled at edge N SHALL produce heater_en or comp_en = 1 after edge N (one clock).
REQ-022 Minimum on-time: heater_en and comp_en SHALL each stay high for at least MIN_ON_CYC consecutive cycles once asserted.
REQ-023 Minimum off-time: the low gap between any two active pulses (heater_en or comp_en, either combination) SHALL be at least MIN_OFF_CYC+1 cycles.
REQ-024 Simultaneous heat=1 and cool=1: SHALL be treated as "no request" by the state machine and SHALL set conflict on the following edge.
REQ-025 conflict SHALL clear only on reset.

Reset
REQ-026 While reset=0, state SHALL be IDLE; heater_en, comp_en, fan_en, busy and conflict SHALL be 0; on_cnt, off_cnt and fan_cnt SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL drop all outputs immediately without waiting for a clock edge, and SHALL discard any pending minimum-on or minimum-off timing.
REQ-028 After reset deasserts, a valid request SHALL be accepted on the first clock edge.

Configuration
REQ-029 Macro FAN_OVERRUN_EN defined: fan_en SHALL be 1 in HEAT and COOL, and for the first min(FAN_POST_CYC, MIN_OFF_CYC) cycles of REST (fan_cnt counter).
REQ-030 Macro FAN_OVERRUN_EN undefined: fan_en SHALL equal heater_en OR comp_en, no fan_cnt SHALL exist, and FAN_POST_CYC SHALL be ignored.

Verification
REQ-031 (all scenarios use default parameters) heat=1 for 2 cycles after reset release, then 0 -> heater_en high for exactly 8 cycles, then busy high for 8 more cycles, then IDLE.
REQ-032 heat=1 for 20 cycles, then cool=1 immediately -> heater_en high for 20 cycles, then both heater_en and comp_en low for 9 cycles, then comp_en rises.
REQ-033 heat=1 and cool=1 in the same cycle while IDLE -> state stays IDLE, conflict=1 from the next cycle and stays 1 until reset.
REQ-034 reset pulled low on cycle 3 of HEAT -> heater_en=0 and busy=0 with no clock edge needed; heat=1 after release -> heater_en=1 one clock later.
REQ-035 FAN_OVERRUN_EN defined, cool=1 for 10 cycles -> fan_en high for 14 cycles; FAN_OVERRUN_EN undefined, same stimulus -> fan_en high for 10 cycles.
REQ-036 All scenarios: an assertion SHALL check that heater_en and comp_en are never both 1.
